// File: rtl/axi_pkg.sv
// Shared AXI write-address constants and the arbiter FSM state type.
package axi_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // IDLE: arbitrating, slave port quiet. BUSY: grant held until AW handshake.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } aw_state_e;

endpackage

// File: rtl/aw_route_fifo.sv
// Routing FIFO recording granted master indices in AW order so the W mux
// can steer write data. Head/valid/full/count come straight from flops.
module aw_route_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_en;
  logic             push_en;

  // Next-state for storage, pointers and occupancy; empty pops are ignored.
  always_comb begin
    pop_en   = pop && (count_q != '0);
    push_en  = push && ((count_q != FULL_CNT) || pop_en);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers, cleared synchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Outputs are pure register reads: no path from pop.
  always_comb begin
    head  = mem_q[rd_ptr_q];
    valid = (count_q != '0);
    full  = (count_q == FULL_CNT);
    count = count_q;
  end

endmodule

// File: rtl/aw_arbiter_mux.sv
// Round-robin AW arbiter/mux: NUM_M masters onto one slave AW port.
// Handshake contract: a transfer occurs on a rising edge where the granted
// master's AWVALID and the slave's AWREADY are both high; the grant is held
// from arbitration until that edge and never withdrawn. AWID_S carries the
// granted master index in its top 4 bits so responses can be routed back,
// and each accepted AW pushes that index into the W routing FIFO.
module aw_arbiter_mux
  import axi_pkg::*;
#(
  parameter int NUM_M    = 2,
  parameter int ID_W     = AXI_ID_BITS,
  parameter int ADDR_W   = AXI_ADDR_BITS,
  parameter int LEN_W    = AXI_LEN_BITS,
  parameter int SIZE_W   = AXI_SIZE_BITS,
  parameter int WQ_DEPTH = 4,
  localparam int IDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [NUM_M*ID_W-1:0]    AWID_M,
  input  logic [NUM_M*ADDR_W-1:0]  AWADDR_M,
  input  logic [NUM_M*LEN_W-1:0]   AWLEN_M,
  input  logic [NUM_M*SIZE_W-1:0]  AWSIZE_M,
  input  logic [NUM_M*2-1:0]       AWBURST_M,
  input  logic [NUM_M-1:0]         AWVALID_M,
  output logic [NUM_M-1:0]         AWREADY_M,
  output logic [ID_W+4-1:0]        AWID_S,
  output logic [ADDR_W-1:0]        AWADDR_S,
  output logic [LEN_W-1:0]         AWLEN_S,
  output logic [SIZE_W-1:0]        AWSIZE_S,
  output logic [1:0]               AWBURST_S,
  output logic                     AWVALID_S,
  input  logic                     AWREADY_S,
  output logic [IDX_W-1:0]         w_route_idx,
  output logic                     w_route_valid,
  input  logic                     w_route_pop
);

  localparam int CNT_W = $clog2(WQ_DEPTH) + 1;

  aw_state_e        state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [IDX_W-1:0] winner;
  logic             winner_found;
  logic             arb_ok;
  logic             hs;

  logic             fifo_push;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;

  // Per-master field views of the flattened input buses.
  logic [ID_W-1:0]   id_arr    [NUM_M];
  logic [ADDR_W-1:0] addr_arr  [NUM_M];
  logic [LEN_W-1:0]  len_arr   [NUM_M];
  logic [SIZE_W-1:0] size_arr  [NUM_M];
  logic [1:0]        burst_arr [NUM_M];

  for (genvar g = 0; g < NUM_M; g++) begin : g_unpack
    assign id_arr[g]    = AWID_M[g*ID_W +: ID_W];
    assign addr_arr[g]  = AWADDR_M[g*ADDR_W +: ADDR_W];
    assign len_arr[g]   = AWLEN_M[g*LEN_W +: LEN_W];
    assign size_arr[g]  = AWSIZE_M[g*SIZE_W +: SIZE_W];
    assign burst_arr[g] = AWBURST_M[g*2 +: 2];
  end

  // Round-robin pick: first requester at or after rr_ptr, wrapping at NUM_M.
  always_comb begin
    int idx;
    winner       = rr_ptr_q;
    winner_found = 1'b0;
    idx          = 0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_M) begin
        idx = idx - NUM_M;
      end
      if (!winner_found && AWVALID_M[idx]) begin
        winner_found = 1'b1;
        winner       = IDX_W'(idx);
      end
    end
  end

  // Grant only while the routing FIFO can take the eventual push.
  always_comb begin
    arb_ok    = (fifo_count < CNT_W'(WQ_DEPTH));
    hs        = (state_q == BUSY) && AWVALID_M[grant_q] && AWREADY_S;
    fifo_push = hs && !fifo_full;
  end

  // FSM state and grant/pointer registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state: IDLE arbitrates, BUSY waits for the handshake.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (arb_ok && winner_found) begin
          state_d = BUSY;
          grant_d = winner;
        end
      end
      BUSY: begin
        if (hs) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == IDX_W'(NUM_M - 1)) ? '0 : grant_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: combinational mux of the granted master in BUSY, all zero in IDLE.
  always_comb begin
    AWID_S     = '0;
    AWADDR_S   = '0;
    AWLEN_S    = '0;
    AWSIZE_S   = '0;
    AWBURST_S  = '0;
    AWVALID_S  = 1'b0;
    AWREADY_M  = '0;
    if (state_q == BUSY) begin
      AWID_S             = {4'(grant_q), id_arr[grant_q]};
      AWADDR_S           = addr_arr[grant_q];
      AWLEN_S            = len_arr[grant_q];
      AWSIZE_S           = size_arr[grant_q];
      AWBURST_S          = burst_arr[grant_q];
      AWVALID_S          = AWVALID_M[grant_q];
      AWREADY_M[grant_q] = AWREADY_S;
    end
  end

  aw_route_fifo #(
    .W     (IDX_W),
    .DEPTH (WQ_DEPTH)
  ) u_route_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (fifo_push),
    .din   (grant_q),
    .pop   (w_route_pop),
    .head  (w_route_idx),
    .valid (w_route_valid),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_aw_arbiter_mux.sv
// Directed bench for aw_arbiter_mux with four masters and a 4-deep route FIFO.
module tb_aw_arbiter_mux;
  import axi_pkg::*;

  localparam int NUM_M    = 4;
  localparam int ID_W     = 4;
  localparam int ADDR_W   = 32;
  localparam int LEN_W    = 4;
  localparam int SIZE_W   = 3;
  localparam int WQ_DEPTH = 4;
  localparam int IDX_W    = 2;

  logic                    aclk;
  logic                    areset;
  logic [NUM_M*ID_W-1:0]   awid_m;
  logic [NUM_M*ADDR_W-1:0] awaddr_m;
  logic [NUM_M*LEN_W-1:0]  awlen_m;
  logic [NUM_M*SIZE_W-1:0] awsize_m;
  logic [NUM_M*2-1:0]      awburst_m;
  logic [NUM_M-1:0]        awvalid_m;
  logic [NUM_M-1:0]        awready_m;
  logic [ID_W+4-1:0]       awid_s;
  logic [ADDR_W-1:0]       awaddr_s;
  logic [LEN_W-1:0]        awlen_s;
  logic [SIZE_W-1:0]       awsize_s;
  logic [1:0]              awburst_s;
  logic                    awvalid_s;
  logic                    awready_s;
  logic [IDX_W-1:0]        w_route_idx;
  logic                    w_route_valid;
  logic                    w_route_pop;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock and reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  aw_arbiter_mux #(
    .NUM_M    (NUM_M),
    .ID_W     (ID_W),
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .SIZE_W   (SIZE_W),
    .WQ_DEPTH (WQ_DEPTH)
  ) dut (
    .ACLK          (aclk),
    .ARESET        (areset),
    .AWID_M        (awid_m),
    .AWADDR_M      (awaddr_m),
    .AWLEN_M       (awlen_m),
    .AWSIZE_M      (awsize_m),
    .AWBURST_M     (awburst_m),
    .AWVALID_M     (awvalid_m),
    .AWREADY_M     (awready_m),
    .AWID_S        (awid_s),
    .AWADDR_S      (awaddr_s),
    .AWLEN_S       (awlen_s),
    .AWSIZE_S      (awsize_s),
    .AWBURST_S     (awburst_s),
    .AWVALID_S     (awvalid_s),
    .AWREADY_S     (awready_s),
    .w_route_idx   (w_route_idx),
    .w_route_valid (w_route_valid),
    .w_route_pop   (w_route_pop)
  );

  // Checker
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_master(input int i, input logic [3:0] id, input logic [31:0] addr);
    awid_m[i*ID_W +: ID_W]       = id;
    awaddr_m[i*ADDR_W +: ADDR_W] = addr;
    awlen_m[i*LEN_W +: LEN_W]    = 4'(i + 1);
    awsize_m[i*SIZE_W +: SIZE_W] = 3'd2;
    awburst_m[i*2 +: 2]          = AXI_BURST_INCR;
    awvalid_m[i]                 = 1'b1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  initial begin
    areset      = 1'b1;
    awid_m      = '0;
    awaddr_m    = '0;
    awlen_m     = '0;
    awsize_m    = '0;
    awburst_m   = '0;
    awvalid_m   = '0;
    awready_s   = 1'b0;
    w_route_pop = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_awvalid_s", 64'(awvalid_s), 64'd0);
    chk("rst_awready_m", 64'(awready_m), 64'd0);
    chk("rst_route_valid", 64'(w_route_valid), 64'd0);
    chk("rst_route_idx", 64'(w_route_idx), 64'd0);
    chk("rst_awid_s", 64'(awid_s), 64'd0);
    chk("rst_awaddr_s", 64'(awaddr_s), 64'd0);
    areset = 1'b0;

    // Single request from master 1
    set_master(1, 4'h3, 32'h1000);
    awready_s = 1'b1;
    chk("single_pre_awvalid", 64'(awvalid_s), 64'd0);
    tick();
    chk("single_awvalid", 64'(awvalid_s), 64'd1);
    chk("single_awid", 64'(awid_s), 64'h13);
    chk("single_awaddr", 64'(awaddr_s), 64'h1000);
    chk("single_awlen", 64'(awlen_s), 64'd2);
    chk("single_awsize", 64'(awsize_s), 64'd2);
    chk("single_awburst", 64'(awburst_s), 64'(AXI_BURST_INCR));
    chk("single_awready_m", 64'(awready_m), 64'b0010);
    chk("single_route_pre", 64'(w_route_valid), 64'd0);
    tick();
    awvalid_m[1] = 1'b0;
    chk("single_route_valid", 64'(w_route_valid), 64'd1);
    chk("single_route_idx", 64'(w_route_idx), 64'd1);
    chk("single_idle_awvalid", 64'(awvalid_s), 64'd0);
    chk("single_idle_awaddr", 64'(awaddr_s), 64'd0);
    w_route_pop = 1'b1;
    tick();
    w_route_pop = 1'b0;
    chk("single_route_drained", 64'(w_route_valid), 64'd0);

    // Round-robin fairness with all masters requesting
    do_reset();
    for (int i = 0; i < NUM_M; i++) begin
      set_master(i, 4'(8 + i), 32'h2000 + 32'(i) * 32'h100);
    end
    awready_s   = 1'b1;
    w_route_pop = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % NUM_M;
      tick();
      chk("rr_awvalid", 64'(awvalid_s), 64'd1);
      chk("rr_awid", 64'(awid_s), 64'((g << 4) | (8 + g)));
      chk("rr_awaddr", 64'(awaddr_s), 64'(32'h2000 + 32'(g) * 32'h100));
      chk("rr_awready_m", 64'(awready_m), 64'(1 << g));
      tick();
      if (k == 4) awvalid_m = '0;
      chk("rr_gap_awvalid", 64'(awvalid_s), 64'd0);
    end
    tick();
    tick();
    w_route_pop = 1'b0;
    chk("rr_route_drained", 64'(w_route_valid), 64'd0);

    // Backpressure: M0 holds the grant while M1 waits (rr_ptr is 1 here)
    awready_s = 1'b0;
    set_master(0, 4'h5, 32'h3000);
    tick();
    set_master(1, 4'h6, 32'h3100);
    for (int c = 0; c < 5; c++) begin
      chk("bp_awvalid", 64'(awvalid_s), 64'd1);
      chk("bp_awid", 64'(awid_s), 64'h05);
      chk("bp_awready_m", 64'(awready_m), 64'd0);
      tick();
    end
    awready_s = 1'b1;
    #1;
    chk("bp_release_awready_m", 64'(awready_m), 64'b0001);
    tick();
    awvalid_m[0] = 1'b0;
    chk("bp_gap_awvalid", 64'(awvalid_s), 64'd0);
    tick();
    chk("bp_m1_awid", 64'(awid_s), 64'h16);
    chk("bp_m1_awready_m", 64'(awready_m), 64'b0010);
    tick();
    awvalid_m[1] = 1'b0;
    chk("bp_route_idx", 64'(w_route_idx), 64'd0);
    chk("bp_route_valid", 64'(w_route_valid), 64'd1);

    // Simultaneous push and pop with two entries queued (0, 1); rr_ptr is 2
    set_master(3, 4'h7, 32'h4000);
    tick();
    chk("pp_awid", 64'(awid_s), 64'h37);
    w_route_pop = 1'b1;
    tick();
    w_route_pop  = 1'b0;
    awvalid_m[3] = 1'b0;
    chk("pp_head_after", 64'(w_route_idx), 64'd1);
    chk("pp_valid_after", 64'(w_route_valid), 64'd1);
    w_route_pop = 1'b1;
    tick();
    w_route_pop = 1'b0;
    chk("pp_head_next", 64'(w_route_idx), 64'd3);
    chk("pp_valid_next", 64'(w_route_valid), 64'd1);
    w_route_pop = 1'b1;
    tick();
    w_route_pop = 1'b0;
    chk("pp_empty", 64'(w_route_valid), 64'd0);

    // FIFO full: M0 requests five times with no pops
    set_master(0, 4'h1, 32'h5000);
    awready_s = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("full_awvalid", 64'(awvalid_s), 64'd1);
      tick();
      chk("full_gap_awvalid", 64'(awvalid_s), 64'd0);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("full_stall_awvalid", 64'(awvalid_s), 64'd0);
    end
    chk("full_route_valid", 64'(w_route_valid), 64'd1);
    w_route_pop = 1'b1;
    tick();
    w_route_pop = 1'b0;
    chk("full_pop_awvalid0", 64'(awvalid_s), 64'd0);
    tick();
    chk("full_pop_awvalid1", 64'(awvalid_s), 64'd1);
    chk("full_pop_awid", 64'(awid_s), 64'h01);
    tick();
    awvalid_m[0] = 1'b0;

    // Reset while BUSY with three FIFO entries
    w_route_pop = 1'b1;
    tick();
    w_route_pop = 1'b0;
    awready_s   = 1'b0;
    set_master(1, 4'h9, 32'h6000);
    tick();
    chk("rb_busy_awvalid", 64'(awvalid_s), 64'd1);
    areset       = 1'b1;
    awvalid_m[1] = 1'b0;
    tick();
    areset = 1'b0;
    chk("rb_awvalid", 64'(awvalid_s), 64'd0);
    chk("rb_route_valid", 64'(w_route_valid), 64'd0);
    chk("rb_route_idx", 64'(w_route_idx), 64'd0);
    chk("rb_awready_m", 64'(awready_m), 64'd0);
    set_master(2, 4'hC, 32'h7000);
    tick();
    chk("rb_m2_awid", 64'(awid_s), 64'h2C);
    chk("rb_m2_awaddr", 64'(awaddr_s), 64'h7000);
    awready_s = 1'b1;
    #1;
    chk("rb_m2_awready_m", 64'(awready_m), 64'b0100);
    tick();
    awvalid_m[2] = 1'b0;
    chk("rb_m2_route_idx", 64'(w_route_idx), 64'd2);
    chk("rb_m2_route_valid", 64'(w_route_valid), 64'd1);

    // After M2, rr_ptr is 3: M0 and M3 together must pick M3
    set_master(0, 4'h2, 32'h8000);
    set_master(3, 4'h4, 32'h8300);
    tick();
    chk("rr_after_reset_awid", 64'(awid_s), 64'h34);
    awvalid_m = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
